// File: rtl/cu_pkg.sv
// Shared types for the accumulator-core control unit:
// opcode map, ALU operation codes, sequencer states.
package cu_pkg;

  localparam int WAIT_W = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_HLT = 4'h7
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_RSVD = 2'd3
  } aluop_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_D,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_HALT
  } state_t;

  function automatic aluop_t alu_of(input opcode_t op);
    aluop_t r;
    r = ALU_PASS;
    if (op == OP_ADD) r = ALU_ADD;
    if (op == OP_SUB) r = ALU_SUB;
    return r;
  endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Memory wait-state counter; flags timeout once the
// count reaches MAX_WAIT while still waiting.
module cu_wait_timer
  import cu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = (r_cnt >= LIMIT);

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the accumulator datapath
// with memory wait states and a bus-timeout watchdog.
module control_unit
  import cu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [3:0] Opcode,
  input  logic       Zflag,
  input  logic       MemReady,
  output logic       SelInc,
  output logic       LoadPC,
  output logic       LoadIR,
  output logic       LoadMAR,
  output logic       LoadAcc,
  output logic [1:0] AluOp,
  output logic       TrisOperand,
  output logic       TrisPC,
  output logic       TrisAcc,
  output logic       TrisMem,
  output logic       WriteMem,
  output logic       IllegalOp,
  output logic       Halted,
  output logic       BusError
);

  state_t  r_state;
  logic    r_buserr;
  opcode_t w_opc;
  logic    w_data;
  logic    w_timeout;
  logic    w_abort;

  assign w_opc = opcode_t'(Opcode);

  assign w_data = (r_state == S_FETCH_D) ||
                  (r_state == S_MEM_RD)  ||
                  (r_state == S_MEM_WR);

  assign w_abort = w_data && !MemReady && w_timeout;

  // Held clear outside data phases, so each phase starts at zero.
  cu_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .i_clk    (Clock),
    .i_rst_n  (nReset),
    .i_clr    (!w_data),
    .i_en     (w_data && !MemReady),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state  <= S_IDLE;
      r_buserr <= 1'b0;
    end else if (w_abort) begin
      r_state  <= S_HALT;
      r_buserr <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE:    r_state <= S_FETCH_A;
        S_FETCH_A: r_state <= S_FETCH_D;
        S_FETCH_D: if (MemReady) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_opc)
            OP_LDA,
            OP_ADD,
            OP_SUB:  r_state <= S_MEM_RD;
            OP_STA:  r_state <= S_MEM_WR;
            OP_HLT:  r_state <= S_HALT;
            default: r_state <= S_FETCH_A;
          endcase
        end
        S_MEM_RD,
        S_MEM_WR:  if (MemReady) r_state <= S_FETCH_A;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    SelInc      = 1'b0;
    LoadPC      = 1'b0;
    LoadIR      = 1'b0;
    LoadMAR     = 1'b0;
    LoadAcc     = 1'b0;
    AluOp       = ALU_PASS;
    TrisOperand = 1'b0;
    TrisPC      = 1'b0;
    TrisAcc     = 1'b0;
    TrisMem     = 1'b0;
    WriteMem    = 1'b0;
    IllegalOp   = 1'b0;
    Halted      = 1'b0;
    BusError    = r_buserr;
    case (r_state)
      S_FETCH_A: begin
        TrisPC  = 1'b1;
        LoadMAR = 1'b1;
      end
      S_FETCH_D: begin
        TrisMem = 1'b1;
        LoadIR  = MemReady;
        LoadPC  = MemReady;
        SelInc  = MemReady;
      end
      S_DECODE: begin
        case (w_opc)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            TrisOperand = 1'b1;
            LoadMAR     = 1'b1;
          end
          OP_JMP: begin
            TrisOperand = 1'b1;
            LoadPC      = 1'b1;
          end
          OP_JZ: begin
            TrisOperand = Zflag;
            LoadPC      = Zflag;
          end
          OP_NOP, OP_HLT: ;
          default: IllegalOp = 1'b1;
        endcase
      end
      S_MEM_RD: begin
        TrisMem = 1'b1;
        LoadAcc = MemReady;
        if (MemReady) AluOp = alu_of(w_opc);
      end
      S_MEM_WR: begin
        TrisAcc  = 1'b1;
        WriteMem = 1'b1;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit
// (built with MAX_WAIT = 4).
module tb_control_unit;

  logic       Clock;
  logic       nReset;
  logic [3:0] Opcode;
  logic       Zflag;
  logic       MemReady;
  logic       SelInc, LoadPC, LoadIR, LoadMAR, LoadAcc;
  logic [1:0] AluOp;
  logic       TrisOperand, TrisPC, TrisAcc, TrisMem;
  logic       WriteMem, IllegalOp, Halted, BusError;

  int checks   = 0;
  int failures = 0;

  control_unit #(
    .MAX_WAIT(4)
  ) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .Opcode     (Opcode),
    .Zflag      (Zflag),
    .MemReady   (MemReady),
    .SelInc     (SelInc),
    .LoadPC     (LoadPC),
    .LoadIR     (LoadIR),
    .LoadMAR    (LoadMAR),
    .LoadAcc    (LoadAcc),
    .AluOp      (AluOp),
    .TrisOperand(TrisOperand),
    .TrisPC     (TrisPC),
    .TrisAcc    (TrisAcc),
    .TrisMem    (TrisMem),
    .WriteMem   (WriteMem),
    .IllegalOp  (IllegalOp),
    .Halted     (Halted),
    .BusError   (BusError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [14:0] w_o;
  assign w_o = {SelInc, LoadPC, LoadIR, LoadMAR, LoadAcc, AluOp,
                TrisOperand, TrisPC, TrisAcc, TrisMem,
                WriteMem, IllegalOp, Halted, BusError};

  localparam logic [14:0] Z    = 15'h0000;
  localparam logic [14:0] SEL  = 15'h4000;
  localparam logic [14:0] LPC  = 15'h2000;
  localparam logic [14:0] LIR  = 15'h1000;
  localparam logic [14:0] LMAR = 15'h0800;
  localparam logic [14:0] LACC = 15'h0400;
  localparam logic [14:0] AADD = 15'h0100;
  localparam logic [14:0] ASUB = 15'h0200;
  localparam logic [14:0] TOP  = 15'h0080;
  localparam logic [14:0] TPC  = 15'h0040;
  localparam logic [14:0] TACC = 15'h0020;
  localparam logic [14:0] TMEM = 15'h0010;
  localparam logic [14:0] WR   = 15'h0008;
  localparam logic [14:0] ILL  = 15'h0004;
  localparam logic [14:0] HLT  = 15'h0002;
  localparam logic [14:0] BERR = 15'h0001;

  localparam logic [14:0] FA   = TPC | LMAR;
  localparam logic [14:0] FDR  = TMEM | LIR | LPC | SEL;
  localparam logic [14:0] DMEM = TOP | LMAR;
  localparam logic [14:0] DJMP = TOP | LPC;
  localparam logic [14:0] MWR  = TACC | WR;
  localparam logic [14:0] DEAD = HLT | BERR;

  always @(negedge Clock) begin
    checks++;
    if ($countones({TrisOperand, TrisPC, TrisAcc, TrisMem}) > 1) begin
      failures++;
      $display("FAIL bus_excl t=%0t tris=%b", $time,
               {TrisOperand, TrisPC, TrisAcc, TrisMem});
    end
  end

  task automatic do_reset();
    nReset   = 1'b0;
    MemReady = 1'b0;
    @(posedge Clock); #1;
    nReset = 1'b1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    Opcode = 4'h0;
    Zflag  = 1'b0;
    MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #2;
      checks++;
      if (w_o !== Z) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, w_o, Z);
      end
    end
    @(posedge Clock); #1;
    nReset = 1'b1;
    #1;
    checks++;
    if (w_o !== Z) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", w_o, Z);
    end
    @(posedge Clock); #2;
    checks++;
    if (w_o !== FA) begin
      failures++;
      $display("FAIL reset_fetch got=%h exp=%h", w_o, FA);
    end
  endtask

  task automatic test_nop();
    logic [14:0] e [$];
    string mr;
    do_reset();
    Opcode = 4'h0;
    e  = '{Z, FA, FDR, Z, FA, FDR};
    mr = "111111";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL nop[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_add_wait();
    logic [14:0] e [$];
    string mr;
    do_reset();
    Opcode = 4'h3;
    e  = '{Z, FA, FDR, DMEM, TMEM, TMEM, TMEM | LACC | AADD, FA};
    mr = "11110011";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL add_wait[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reads();
    logic [14:0] e [$];
    logic [3:0]  ops [3];
    logic [14:0] rd  [3];
    ops = '{4'h1, 4'h3, 4'h4};
    rd  = '{TMEM | LACC, TMEM | LACC | AADD, TMEM | LACC | ASUB};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      Opcode = ops[k];
      e = '{Z, FA, FDR, DMEM, rd[k], FA};
      for (int i = 0; i < e.size(); i++) begin
        MemReady = 1'b1;
        #1;
        checks++;
        if (w_o !== e[i]) begin
          failures++;
          $display("FAIL read_op%0h[%0d] got=%h exp=%h",
                   ops[k], i, w_o, e[i]);
        end
        @(posedge Clock); #1;
      end
    end
  endtask

  task automatic test_jumps();
    logic [14:0] e [$];
    logic [3:0]  ops [3];
    logic        zs  [3];
    logic [14:0] dec [3];
    ops = '{4'h6, 4'h6, 4'h5};
    zs  = '{1'b1, 1'b0, 1'b0};
    dec = '{DJMP, Z, DJMP};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      Opcode = ops[k];
      Zflag  = zs[k];
      e = '{Z, FA, FDR, dec[k], FA};
      for (int i = 0; i < e.size(); i++) begin
        MemReady = 1'b1;
        #1;
        checks++;
        if (w_o !== e[i]) begin
          failures++;
          $display("FAIL jump_op%0h_z%0d[%0d] got=%h exp=%h",
                   ops[k], zs[k], i, w_o, e[i]);
        end
        @(posedge Clock); #1;
      end
    end
    Zflag = 1'b0;
  endtask

  task automatic test_sta();
    logic [14:0] e [$];
    string mr;
    do_reset();
    Opcode = 4'h2;
    e  = '{Z, FA, FDR, DMEM, MWR, FA, FDR};
    mr = "1111111";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL sta[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
    do_reset();
    e  = '{Z, FA, FDR, DMEM, MWR, MWR, FA};
    mr = "1111011";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL sta_wait[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_illegal();
    logic [14:0] e [$];
    logic [3:0]  ops [2];
    ops = '{4'h9, 4'hF};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      Opcode = ops[k];
      e = '{Z, FA, FDR, ILL, FA, FDR, ILL};
      for (int i = 0; i < e.size(); i++) begin
        MemReady = 1'b1;
        #1;
        checks++;
        if (w_o !== e[i]) begin
          failures++;
          $display("FAIL illegal_op%0h[%0d] got=%h exp=%h",
                   ops[k], i, w_o, e[i]);
        end
        @(posedge Clock); #1;
      end
    end
  endtask

  task automatic test_halt();
    logic [14:0] e [$];
    do_reset();
    Opcode = 4'h7;
    e = '{Z, FA, FDR, Z, HLT};
    for (int i = 0; i < e.size(); i++) begin
      MemReady = 1'b1;
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL hlt[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
    for (int i = 0; i < 50; i++) begin
      MemReady = i[0];
      Zflag    = i[1];
      #1;
      checks++;
      if (w_o !== HLT) begin
        failures++;
        $display("FAIL hlt_hold[%0d] got=%h exp=%h", i, w_o, HLT);
      end
      @(posedge Clock); #1;
    end
    Zflag = 1'b0;
  endtask

  task automatic test_timeout();
    logic [14:0] e [$];
    string mr;
    do_reset();
    Opcode = 4'h0;
    e  = '{Z, FA, TMEM, TMEM, TMEM, TMEM, TMEM, DEAD,
           DEAD, DEAD, DEAD, DEAD};
    mr = "000000001101";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL fetch_timeout[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
    nReset = 1'b0;
    #1;
    checks++;
    if (w_o !== Z) begin
      failures++;
      $display("FAIL timeout_clear got=%h exp=%h", w_o, Z);
    end
    @(posedge Clock); #1;
    nReset = 1'b1;
    MemReady = 1'b1;
    @(posedge Clock); #2;
    checks++;
    if (w_o !== FA) begin
      failures++;
      $display("FAIL timeout_restart got=%h exp=%h", w_o, FA);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_wait_boundary();
    logic [14:0] e [$];
    string mr;
    do_reset();
    Opcode = 4'h1;
    e  = '{Z, FA, TMEM, TMEM, TMEM, FDR, DMEM,
           TMEM, TMEM, TMEM, TMEM, TMEM | LACC, FA};
    mr = "1100011000011";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL wait_edge[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
    do_reset();
    Opcode = 4'h2;
    e  = '{Z, FA, FDR, DMEM, MWR, MWR, MWR, MWR, MWR, DEAD};
    mr = "1111000001";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL wr_timeout[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] e [$];
    string mr;
    do_reset();
    Opcode = 4'h3;
    e  = '{Z, FA, FDR, DMEM, TMEM};
    mr = "11110";
    for (int i = 0; i < e.size(); i++) begin
      MemReady = (mr[i] == "1");
      #1;
      checks++;
      if (w_o !== e[i]) begin
        failures++;
        $display("FAIL mid_pre[%0d] got=%h exp=%h", i, w_o, e[i]);
      end
      @(posedge Clock); #1;
    end
    MemReady = 1'b1;
    nReset   = 1'b0;
    #1;
    checks++;
    if (w_o !== Z) begin
      failures++;
      $display("FAIL mid_abort got=%h exp=%h", w_o, Z);
    end
    @(posedge Clock); #1;
    nReset = 1'b1;
    #1;
    checks++;
    if (w_o !== Z) begin
      failures++;
      $display("FAIL mid_idle got=%h exp=%h", w_o, Z);
    end
    @(posedge Clock); #2;
    checks++;
    if (w_o !== FA) begin
      failures++;
      $display("FAIL mid_refetch got=%h exp=%h", w_o, FA);
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    nReset   = 1'b0;
    Opcode   = 4'h0;
    Zflag    = 1'b0;
    MemReady = 1'b0;
    test_reset();
    test_nop();
    test_add_wait();
    test_reads();
    test_jumps();
    test_sta();
    test_illegal();
    test_halt();
    test_timeout();
    test_wait_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Instruction sequencer for the accumulator datapath. It consumes Opcode and Zflag from the datapath and drives the datapath strobes (SelInc, LoadPC, LoadIR, Tris*), plus LoadAcc, AluOp, LoadMAR and the memory handshake. It enforces single-driver use of the shared SysBus. It runs the fetch / decode / execute loop with a memory wait-state handshake and a bus-timeout watchdog.

Parameters:
MAX_WAIT, 15, maximum cycles the block waits in any memory data phase for MemReady before aborting (range 1..255).

Ports:
Clock  input  1  system clock, rising edge.
nReset  input  1  asynchronous active-low reset.
Opcode  input  4  IR[15:12] from the datapath.
Zflag  input  1  accumulator-zero flag from the datapath.
MemReady  input  1  memory completed the current data phase this cycle.
SelInc  output  1  PC source select: 1 = PC+1, 0 = SysBus.
LoadPC  output  1  PC load enable.
LoadIR  output  1  IR load enable (captures SysBus).
LoadMAR  output  1  memory address register load (captures SysBus).
LoadAcc  output  1  accumulator load enable.
AluOp  output  2  0 = PASS, 1 = ADD, 2 = SUB, 3 = reserved.
TrisOperand  output  1  IR[11:0] drives SysBus.
TrisPC  output  1  PC drives SysBus.
TrisAcc  output  1  accumulator drives SysBus.
TrisMem  output  1  memory drives SysBus (read enable).
WriteMem  output  1  memory write strobe.
IllegalOp  output  1  one-cycle pulse on an undefined opcode.
Halted  output  1  sticky; core stopped.
BusError  output  1  sticky; MemReady timeout occurred.

Behaviour:
- Clock and reset: single clock domain. nReset low asynchronously forces state IDLE, clears the wait counter, BusError and the Halted source.
- Outputs: all are decoded from state plus inputs, and all are 0 in IDLE. Therefore every output reads 0 during reset and for the first cycle after reset.
- Opcode map: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 HLT, 8-F illegal.
- Bus rule: at most one of TrisOperand, TrisPC, TrisAcc, TrisMem is high in any cycle. This is an invariant, including across reset and abort.
- State IDLE: -> FETCH_A unconditionally.
- State FETCH_A: TrisPC = 1, LoadMAR = 1 -> FETCH_D.
- State FETCH_D: TrisMem = 1.
  - MemReady = 0: stay, wait counter increments.
  - MemReady = 1: LoadIR = 1, LoadPC = 1, SelInc = 1 in the same cycle -> DECODE.
- State DECODE: Opcode and Zflag are sampled this cycle.
  - LDA / ADD / SUB: TrisOperand = 1, LoadMAR = 1 -> MEM_RD.
  - STA: TrisOperand = 1, LoadMAR = 1 -> MEM_WR.
  - JMP: TrisOperand = 1, LoadPC = 1, SelInc = 0 -> FETCH_A.
  - JZ: behaves as JMP if Zflag = 1, otherwise as NOP.
  - NOP: no strobes -> FETCH_A.
  - HLT: -> HALT.
  - Illegal: IllegalOp = 1 for this cycle, no other strobes -> FETCH_A.
- State MEM_RD: TrisMem = 1 until MemReady. In the MemReady cycle, LoadAcc = 1 with AluOp = PASS (LDA), ADD or SUB -> FETCH_A. The opcode is held from IR, which is stable.
- State MEM_WR: TrisAcc = 1 and WriteMem = 1 until and including the MemReady cycle -> FETCH_A.
- State HALT: Halted = 1, no strobes. Only reset exits.
- Watchdog: the wait counter is 8 bits wide, cleared on entry to each data phase (FETCH_D, MEM_RD, MEM_WR).
  - If MAX_WAIT cycles elapse with MemReady low, the next edge sets BusError and moves to HALT; all Tris outputs drop on that edge.
  - MemReady arriving in cycle MAX_WAIT is accepted normally.
- Cycle counts, zero wait states:
  - NOP, JMP, JZ, illegal: 3 cycles.
  - LDA, ADD, SUB, STA: 4 cycles.
  - Each MemReady-low cycle adds 1.
- MemReady outside a data phase is ignored.
- Reset mid-phase aborts immediately. No partial load occurs after the reset edge.

Decomposition:
- Package cu_pkg holds:
  - opcode_t: 4-bit enum of the opcode map.
  - aluop_t: enum of AluOp values.
  - state_t: enum IDLE, FETCH_A, FETCH_D, DECODE, MEM_RD, MEM_WR, HALT.
  - Constant WAIT_W = 8.
- One sub-module, cu_wait_timer: counter with clear / enable and a timeout output. Used by the FSM in all data phases.
- The output decode stays in control_unit.

Test Plan:
- Reset then MemReady tied 1, instruction NOP -> state sequence IDLE, FETCH_A, FETCH_D, DECODE, FETCH_A. In FETCH_D: LoadIR = LoadPC = SelInc = 1. No two Tris signals are ever high together.
- Opcode 3 (ADD), MemReady low for 2 cycles in MEM_RD -> TrisMem high for 3 cycles; LoadAcc = 1 with AluOp = 1 only in the third; 6 cycles total.
- Opcode 6 (JZ): with Zflag = 1 -> TrisOperand = 1, LoadPC = 1, SelInc = 0 in DECODE. With Zflag = 0 -> no strobes in DECODE.
- Opcode 2 (STA), MemReady on first cycle -> DECODE: TrisOperand = 1, LoadMAR = 1. Next cycle: TrisAcc = 1, WriteMem = 1 for exactly 1 cycle.
- MAX_WAIT = 4, MemReady held low in FETCH_D -> BusError and Halted rise on the 5th edge; all outputs otherwise 0. Pulsing MemReady afterwards changes nothing; nReset low clears both flags.
- Opcode 9 -> IllegalOp high for exactly one cycle, then fetch resumes. Opcode 7 -> Halted stays 1 for 50 cycles.
